// File: rtl/latch_bank_pkg.sv
// Shared types for the latch bank write controller: FSM state encoding and requester ids.
package latch_bank_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        GATE,
        HOLD,
        ACK
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Requester handshakes and latch-bank drive bus for latch_bank_ctrl.
// LATCH_BANK_ADDR_CHECK_EN adds the addr_err / err_sticky status outputs.
interface latch_bank_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
);
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [WIDTH-1:0]  data0, data1;
    logic              ack0, ack1;
    logic [DEPTH-1:0]  latch_en;
    logic [WIDTH-1:0]  latch_d;
    logic              busy;
    logic              grant_id;
`ifdef LATCH_BANK_ADDR_CHECK_EN
    logic              addr_err;
    logic              err_sticky;
`endif

    modport master (
        output req0, addr0, data0, req1, addr1, data1,
        input  ack0, ack1, latch_en, latch_d, busy, grant_id
`ifdef LATCH_BANK_ADDR_CHECK_EN
        , input addr_err, err_sticky
`endif
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1,
        output ack0, ack1, latch_en, latch_d, busy, grant_id
`ifdef LATCH_BANK_ADDR_CHECK_EN
        , output addr_err, err_sticky
`endif
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; combinational, pointer names the favoured requester on a tie.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt_vld,
    output logic gnt_id
);
    assign gnt_vld = req0 | req1;
    assign gnt_id  = (req0 & req1) ? ptr : req1;
endmodule

// File: rtl/latch_bank_ctrl.sv
// Write controller for a bank of level-sensitive latches: data set up, one gate pulse, data held.
// LATCH_BANK_ADDR_CHECK_EN adds out-of-range address reporting (addr_err, err_sticky).
module latch_bank_ctrl
    import latch_bank_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input logic              clk,
    input logic              rst_n,
    latch_bank_ctrl_if.slave bus
);
    state_t            state;
    logic              ptr;
    logic [ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0]  en_dec;
    logic              gnt_vld, gnt_id;

    rr_arb2 u_arb (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .ptr     (ptr),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    // Addresses past DEPTH decode to no bit, so the gate pulse is suppressed for free.
    always_comb begin
        en_dec = '0;
        for (int i = 0; i < DEPTH; i++)
            if (addr_q == ADDR_W'(i)) en_dec[i] = 1'b1;
    end

`ifdef LATCH_BANK_ADDR_CHECK_EN
    logic in_range;
    assign in_range = |en_dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= REQ0;
            addr_q       <= '0;
            bus.latch_en <= '0;
            bus.latch_d  <= '0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.grant_id <= REQ0;
`ifdef LATCH_BANK_ADDR_CHECK_EN
            bus.addr_err   <= 1'b0;
            bus.err_sticky <= 1'b0;
`endif
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
`ifdef LATCH_BANK_ADDR_CHECK_EN
            bus.addr_err <= 1'b0;
`endif
            case (state)
                IDLE: if (gnt_vld) begin
                    state        <= SETUP;
                    bus.busy     <= 1'b1;
                    bus.grant_id <= gnt_id;
                    addr_q       <= (gnt_id == REQ1) ? bus.addr1 : bus.addr0;
                    bus.latch_d  <= (gnt_id == REQ1) ? bus.data1 : bus.data0;
                end
                SETUP: begin
                    state        <= GATE;
                    bus.latch_en <= en_dec;
                end
                GATE: begin
                    state        <= HOLD;
                    bus.latch_en <= '0;
                end
                HOLD: begin
                    state    <= ACK;
                    bus.ack0 <= (bus.grant_id == REQ0);
                    bus.ack1 <= (bus.grant_id == REQ1);
`ifdef LATCH_BANK_ADDR_CHECK_EN
                    bus.addr_err   <= ~in_range;
                    bus.err_sticky <= bus.err_sticky | ~in_range;
`endif
                end
                ACK: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    ptr      <= other_req(bus.grant_id);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/latch_bank_ctrl.md
Name: latch_bank_ctrl

Overview:
- Write controller for a bank of DEPTH level-sensitive D latches, each WIDTH bits wide.
- Two requesters share the bank; the controller arbitrates between them round-robin.
- For each write it presents data, then pulses exactly one latch gate, then holds data, so setup and hold around the gate are guaranteed by construction.
- Sits between requester logic and the latch array; this is the only block that drives latch gates.

Parameters:
- WIDTH, 8, data bits per latch word.
- DEPTH, 4, number of latch words (latch_en bits).
- ADDR_W, 2, address width; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 write request; held until ack0.
- addr0  in  ADDR_W  requester 0 target word.
- data0  in  WIDTH  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, addr1, data1, ack1: same as above, for requester 1.
- latch_en  out  DEPTH  one-hot latch gate enables to the bank.
- latch_d  out  WIDTH  shared data bus to all latch D inputs.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  requester currently being served; valid while busy.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; latch_en=0 (gates close immediately); latch_d=0; ack0=ack1=0; busy=0; grant_id=0; priority pointer favours requester 0.
- All outputs are registered; latch_en never glitches.
- FSM transitions, one per clock: IDLE -> SETUP -> GATE -> HOLD -> ACK -> IDLE.
- IDLE:
  - No request sampled: stay in IDLE.
  - Exactly one request sampled: grant it.
  - Both requests sampled: grant the requester named by the priority pointer.
  - On grant: capture addr and data into internal registers, set grant_id, go to SETUP.
- SETUP: latch_d = captured data; latch_en=0.
- GATE: latch_en[captured addr]=1; all other bits 0; latch_d unchanged.
- HOLD: latch_en=0; latch_d unchanged.
- ACK: ack of the granted requester =1 for this cycle only; priority pointer moves to the other requester; latch_d keeps its value until the next SETUP.
- Timing: request sampled at edge n gives SETUP in cycle n+1, GATE in n+2, HOLD in n+3, ack in n+4.
  - Minimum transaction is 5 cycles including the IDLE sample.
- Request rules:
  - Requesters hold req/addr/data stable until ack.
  - Inputs are captured at grant, so later changes have no effect on the write in progress.
  - A req still high in the cycle after ack is treated as a new request.
  - Withdrawing req mid-transaction does not abort the write.
- Fairness: with both requesters continuously asserting, grants alternate 0,1,0,1.
- Out-of-range address (addr >= DEPTH): the FSM runs normally, but latch_en stays all-zero in GATE and the ack is still issued.
- Reset mid-transaction: the write is abandoned, no ack is issued, and latch contents are whatever the bank holds.

Optional Feature:
- Macro: LATCH_BANK_ADDR_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0).
  - addr_err pulses high in the ACK cycle when the captured address >= DEPTH.
  - Adds output err_sticky (1 bit), cleared only by reset.
- Undefined: neither port exists; out-of-range writes are silently suppressed as described in Behaviour.

Decomposition:
- Package latch_bank_pkg holds:
  - state enum (IDLE, SETUP, GATE, HOLD, ACK);
  - requester-id constants REQ0=0, REQ1=1.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req0, req1, pointer.
  - Outputs: grant valid, grant id.
  - Purely combinational; the pointer register stays in latch_bank_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-run -> latch_en=0, ack0/ack1=0, busy=0, latch_d=0 immediately (before the next edge).
- Single write: req0=1, addr0=2, data0=8'hA5 sampled at edge n -> latch_d=8'hA5 in cycles n+1..n+3, latch_en=4'b0100 only in cycle n+2, ack0=1 only in n+4.
- Contention: req0=req1=1 held continuously after reset -> grant_id sequence 0,1,0,1; each ack is one cycle, with 5-cycle spacing.
- Data capture: change data0 from 8'h11 to 8'hFF during SETUP -> latch_d stays 8'h11 through HOLD.
- Abort: rst_n low during GATE -> latch_en drops asynchronously; no ack; after release the next req0 is served normally.
- Range: DEPTH=3, addr1=3, macro defined -> latch_en stays 0, ack1 and addr_err pulse together, err_sticky=1 until reset.
